// File: rtl/button_debounce_array.sv
// -----------------------------------------------------------------------------
// button_debounce_array
//
// Multi-channel push-button conditioner. Every channel normalises the polarity
// of its raw input, passes it through a two-flop synchroniser and then through
// a four-state debounce FSM that only accepts a level change after the
// synchronised input has stayed at the new level for DEBOUNCE_CYCLES
// consecutive clocks. Accepted presses and releases produce single-cycle
// pulses. While a button is held with repeat_en set, an auto-repeat pulse fires
// REPEAT_DELAY cycles after the press and then every REPEAT_PERIOD cycles.
// Channels are completely independent of each other.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   button_signal  [CHANNELS] raw asynchronous button inputs
//   repeat_en      [CHANNELS] per-channel auto-repeat enable (synchronous)
//   button_state   [CHANNELS] debounced level, 1 = pressed
//   press_pulse    [CHANNELS] one-cycle pulse on accepted press
//   release_pulse  [CHANNELS] one-cycle pulse on accepted release
//   repeat_pulse   [CHANNELS] one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_debounce_array #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button_signal,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] button_state,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_W    = $clog2(REP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_PERIOD = RP_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Polarity is fixed before the synchroniser so that "1 = pressed" holds
  // everywhere downstream, including the reset value of the sync flops.
  logic [CHANNELS-1:0] btn_norm;
  assign btn_norm = (ACTIVE_LOW != 0) ? ~button_signal : button_signal;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

    logic            sync_0_q;
    logic            sync_1_q;
    state_t          state_q,     state_d;
    logic [DB_W-1:0] db_cnt_q,    db_cnt_d;
    logic [RP_W-1:0] rep_cnt_q,   rep_cnt_d;
    logic            rep_armed_q, rep_armed_d;
    logic            level_q,     level_d;
    logic            press_q,     press_d;
    logic            rel_q,       rel_d;
    logic            rep_q,       rep_d;
    logic [DB_W-1:0] db_next;
    logic [RP_W-1:0] rep_next;

    // Debounce FSM. The counter holds the number of consecutive cycles the
    // synchronised input has been seen at the candidate level; entering a
    // WAIT state already counts the first such cycle.
    always_comb begin
      db_next  = db_cnt_q + DB_W'(1);
      state_d  = state_q;
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_1_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // A single stable cycle is already enough to accept.
              state_d  = HELD;
              level_d  = 1'b1;
              press_d  = 1'b1;
              db_cnt_d = '0;
            end else begin
              state_d  = PRESS_WAIT;
              db_cnt_d = DB_W'(1);
            end
          end else begin
            db_cnt_d = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_1_q) begin
            state_d  = IDLE;
            db_cnt_d = '0;
          end else if (db_next == DB_LAST) begin
            state_d  = HELD;
            level_d  = 1'b1;
            press_d  = 1'b1;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_next;
          end
        end
        HELD: begin
          if (!sync_1_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d  = IDLE;
              level_d  = 1'b0;
              rel_d    = 1'b1;
              db_cnt_d = '0;
            end else begin
              state_d  = RELEASE_WAIT;
              db_cnt_d = DB_W'(1);
            end
          end else begin
            db_cnt_d = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync_1_q) begin
            state_d  = HELD;
            db_cnt_d = '0;
          end else if (db_next == DB_LAST) begin
            state_d  = IDLE;
            level_d  = 1'b0;
            rel_d    = 1'b1;
            db_cnt_d = '0;
          end else begin
            db_cnt_d = db_next;
          end
        end
        default: begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end
      endcase
    end

    // Auto-repeat. Counting happens only on cycles that start in HELD; a cycle
    // spent in RELEASE_WAIT freezes the count, so a release bounce merely delays
    // the schedule. A direct HELD->IDLE release (single-cycle debounce) never
    // counts, which keeps repeat and release pulses apart. press_d marks the
    // fresh entry into HELD, where the schedule restarts from zero.
    always_comb begin
      rep_next    = rep_cnt_q + RP_W'(1);
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      rep_d       = 1'b0;
      if (!repeat_en[ch] || press_d) begin
        rep_cnt_d   = '0;
        rep_armed_d = 1'b0;
      end else if (state_q == HELD && state_d != IDLE) begin
        if (!rep_armed_q) begin
          if (rep_next == RP_DELAY) begin
            rep_d       = 1'b1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
          end else begin
            rep_cnt_d = rep_next;
          end
        end else begin
          if (rep_next == RP_PERIOD) begin
            rep_d     = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_next;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_0_q    <= 1'b0;
        sync_1_q    <= 1'b0;
        state_q     <= IDLE;
        db_cnt_q    <= '0;
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        rel_q       <= 1'b0;
        rep_q       <= 1'b0;
      end else begin
        sync_0_q    <= btn_norm[ch];
        sync_1_q    <= sync_0_q;
        state_q     <= state_d;
        db_cnt_q    <= db_cnt_d;
        rep_cnt_q   <= rep_cnt_d;
        rep_armed_q <= rep_armed_d;
        level_q     <= level_d;
        press_q     <= press_d;
        rel_q       <= rel_d;
        rep_q       <= rep_d;
      end
    end

    assign button_state[ch]  = level_q;
    assign press_pulse[ch]   = press_q;
    assign release_pulse[ch] = rel_q;
    assign repeat_pulse[ch]  = rep_q;

  end

endmodule

// File: tb/tb_button_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_array
//
// Directed bench for button_debounce_array. Instance dut_a: 2 channels,
// active-high, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Instance dut_b: 4 channels, active-low, same timing. Edge numbers in the
// step comments count rising clock edges after the input change.
// -----------------------------------------------------------------------------
module tb_button_debounce_array;

  logic       clk;
  logic       rst_n;
  logic [1:0] a_btn, a_ren, a_state, a_press, a_rel, a_rep;
  logic [3:0] b_btn, b_ren, b_state, b_press, b_rel, b_rep;

  int checks   = 0;
  int failures = 0;

  int   n_press = 0, n_rel = 0, n_rep = 0;
  int   n_b_press0 = 0, n_b_press2 = 0;
  logic b_silent = 1'b0;

  button_debounce_array #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .button_signal(a_btn), .repeat_en(a_ren),
    .button_state(a_state), .press_pulse(a_press),
    .release_pulse(a_rel), .repeat_pulse(a_rep)
  );

  button_debounce_array #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .button_signal(b_btn), .repeat_en(b_ren),
    .button_state(b_state), .press_pulse(b_press),
    .release_pulse(b_rel), .repeat_pulse(b_rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (a_press[0]) n_press++;
    if (a_rel[0])   n_rel++;
    if (a_rep[0])   n_rep++;
    if (b_press[0]) n_b_press0++;
    if (b_press[2]) n_b_press2++;
    if (b_state[1] | b_state[3] | b_press[1] | b_press[3] |
        b_rel[1] | b_rel[3] | b_rep[1] | b_rep[3]) b_silent = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int p0, r0, q0;

  initial begin
    rst_n = 1'b0;
    a_btn = 2'b00;
    a_ren = 2'b00;
    b_btn = 4'hF;
    b_ren = 4'h0;
    tick(3);
    chk("reset_a_outputs", {a_state, a_press, a_rel, a_rep}, 0);
    chk("reset_b_outputs", {b_state, b_press, b_rel, b_rep}, 0);
    rst_n = 1'b1;
    tick(3);
    chk("b_idle_after_reset", b_state, 0);

    // Clean press held 20 cycles, repeat disabled.
    p0 = n_press; r0 = n_rel; q0 = n_rep;
    a_btn[0] = 1'b1;
    tick(5);                                           // edge 5
    chk("t1_before_press", {a_state[0], a_press[0]}, 2'b00);
    tick(1);                                           // edge 6
    chk("t1_press", {a_state[0], a_press[0]}, 2'b11);
    tick(1);                                           // edge 7
    chk("t1_press_one_cycle", {a_state[0], a_press[0]}, 2'b10);
    tick(13);                                          // edge 20
    a_btn[0] = 1'b0;
    tick(5);                                           // release edge 5
    chk("t1_before_release", {a_state[0], a_rel[0]}, 2'b10);
    tick(1);                                           // release edge 6
    chk("t1_release", {a_state[0], a_rel[0]}, 2'b01);
    tick(1);
    chk("t1_release_one_cycle", {a_state[0], a_rel[0]}, 2'b00);
    tick(3);
    chk("t1_press_count", n_press - p0, 1);
    chk("t1_no_repeat_when_disabled", n_rep - q0, 0);
    chk("t1_ch1_silent", {a_state[1], a_press[1], a_rel[1], a_rep[1]}, 0);

    // Bounce: 3 high, 1 low, 3 high -> rejected; then 4 high -> accepted.
    p0 = n_press; r0 = n_rel;
    a_btn[0] = 1'b1; tick(3);
    a_btn[0] = 1'b0; tick(1);
    a_btn[0] = 1'b1; tick(3);
    a_btn[0] = 1'b0; tick(12);
    chk("t2_bounce_no_press", n_press - p0, 0);
    chk("t2_bounce_state_low", a_state[0], 0);
    a_btn[0] = 1'b1; tick(4);
    a_btn[0] = 1'b0; tick(12);
    chk("t2_min_pulse_one_press", n_press - p0, 1);
    chk("t2_min_pulse_one_release", n_rel - r0, 1);
    chk("t2_state_low_after", a_state[0], 0);

    // Auto-repeat: press at edge 6, repeats at 16,19,...,37; release edge 42.
    p0 = n_press; r0 = n_rel; q0 = n_rep;
    a_ren[0] = 1'b1;
    a_btn[0] = 1'b1;
    tick(6);
    chk("t3_press", a_press[0], 1);
    tick(9);                                           // edge 15
    chk("t3_no_early_repeat", a_rep[0], 0);
    tick(1);                                           // edge 16
    chk("t3_first_repeat", {a_rep[0], a_press[0]}, 2'b10);
    tick(1);                                           // edge 17
    chk("t3_repeat_one_cycle", a_rep[0], 0);
    tick(2);                                           // edge 19
    chk("t3_second_repeat", a_rep[0], 1);
    tick(17);                                          // edge 36
    a_btn[0] = 1'b0;
    tick(6);                                           // edge 42
    chk("t3_release_no_repeat", {a_rel[0], a_rep[0]}, 2'b10);
    tick(3);
    chk("t3_repeat_count", n_rep - q0, 8);
    chk("t3_press_count", n_press - p0, 1);
    chk("t3_release_count", n_rel - r0, 1);

    // Release bounce of 2 cycles while held shifts the repeats to 18,21,24.
    p0 = n_press; r0 = n_rel; q0 = n_rep;
    a_btn[0] = 1'b1;
    tick(10);                                          // edge 10
    a_btn[0] = 1'b0;
    tick(2);                                           // edge 12
    a_btn[0] = 1'b1;
    tick(4);                                           // edge 16
    chk("t6_unshifted_slot_empty", a_rep[0], 0);
    tick(2);                                           // edge 18
    chk("t6_shifted_first_repeat", a_rep[0], 1);
    tick(3);                                           // edge 21
    chk("t6_shifted_second_repeat", a_rep[0], 1);
    tick(1);                                           // edge 22
    chk("t6_no_release_on_bounce", n_rel - r0, 0);
    chk("t6_state_held", a_state[0], 1);
    a_btn[0] = 1'b0;
    tick(10);
    chk("t6_repeat_count", n_rep - q0, 3);
    chk("t6_release_count", n_rel - r0, 1);
    chk("t6_press_count", n_press - p0, 1);
    a_ren[0] = 1'b0;

    // Active-low instance: channel 0 then channel 2, two cycles apart.
    p0 = n_b_press0; q0 = n_b_press2;
    b_btn[0] = 1'b0;
    tick(2);
    b_btn[2] = 1'b0;
    tick(4);                                           // ch0 edge 6
    chk("t4_ch0_press", b_press, 4'b0001);
    tick(1);
    chk("t4_between_presses", {b_state, b_press}, {4'b0001, 4'b0000});
    tick(1);                                           // ch2 edge 6
    chk("t4_ch2_press", {b_state, b_press}, {4'b0101, 4'b0100});
    b_btn = 4'hF;
    tick(12);
    chk("t4_all_released", b_state, 0);
    chk("t4_ch0_one_press", n_b_press0 - p0, 1);
    chk("t4_ch2_one_press", n_b_press2 - q0, 1);
    chk("t4_ch1_ch3_silent", b_silent, 0);

    // Reset during PRESS_WAIT and during HELD with the button kept pressed.
    a_btn[0] = 1'b1;
    tick(4);                                           // PRESS_WAIT
    rst_n = 1'b0;
    tick(2);
    chk("t5_reset_in_press_wait", {a_state, a_press, a_rel, a_rep}, 0);
    rst_n = 1'b1;
    tick(5);
    chk("t5_no_early_press", a_press[0], 0);
    tick(1);
    chk("t5_redetect_press", {a_state[0], a_press[0]}, 2'b11);
    tick(2);
    chk("t5_held", a_state[0], 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_clear_in_held", {a_state, a_press, a_rel, a_rep}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t5_no_early_press_2", a_press[0], 0);
    tick(1);
    chk("t5_redetect_press_2", {a_state[0], a_press[0]}, 2'b11);
    a_btn[0] = 1'b0;
    tick(10);
    chk("t5_released_at_end", a_state[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce_array.md
# button_debounce_array

Parametrised multi-channel push-button conditioner sitting between the raw board buttons and the LCD controller's command logic. Each channel synchronises its raw input, debounces both press and release with a programmable stable-time, and produces a debounced level plus single-cycle press, release and optional auto-repeat event pulses. It generalises the single-channel press-only debouncer to N channels, both edges, selectable input polarity and hold-to-repeat.

## Interface

- CHANNELS, 4, number of independent button channels (>=1)
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (>=1)
- REPEAT_DELAY, 25000000, held cycles from press_pulse to first repeat_pulse (>=1)
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat_pulses (>=1)
- ACTIVE_LOW, 0, 1 = raw input reads 0 when pressed; inverted before synchroniser

- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- button_signal  in  CHANNELS  raw asynchronous button inputs
- repeat_en  in  CHANNELS  per-channel auto-repeat enable, synchronous to clk
- button_state  out  CHANNELS  debounced level, 1 = pressed
- press_pulse  out  CHANNELS  one-cycle pulse on accepted press
- release_pulse  out  CHANNELS  one-cycle pulse on accepted release
- repeat_pulse  out  CHANNELS  one-cycle auto-repeat pulse while held

## Operation

- Per channel: polarity-normalised input -> two-flop synchroniser (sync_0, sync_1) -> FSM + debounce counter + repeat counter. Channels fully independent.
- Debounce counter width $clog2(DEBOUNCE_CYCLES+1); repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Counters never wrap.
- FSM states: IDLE (released, stable), PRESS_WAIT, HELD (pressed, stable), RELEASE_WAIT.
- IDLE: sync_1=1 -> PRESS_WAIT, counter=1. sync_1=0 -> stay, counter=0.
- PRESS_WAIT: sync_1=0 -> IDLE, counter=0 (glitch rejected, no pulse). sync_1=1 and counter+1==DEBOUNCE_CYCLES -> HELD, button_state=1, press_pulse=1, counter=0. Else counter+1. With DEBOUNCE_CYCLES=1 the IDLE->PRESS_WAIT edge itself completes: IDLE goes straight to HELD.
- HELD / RELEASE_WAIT: mirror image with sync_1=0; acceptance -> IDLE, button_state=0, release_pulse=1.
- Repeat: counter active only in HELD with repeat_en=1; holds value in RELEASE_WAIT; cleared on entering HELD from PRESS_WAIT and whenever repeat_en=0. First repeat_pulse when count reaches REPEAT_DELAY, then count reloads and fires every REPEAT_PERIOD. Bounce into RELEASE_WAIT and back to HELD resumes without restart.
- repeat_pulse never coincides with press_pulse or release_pulse on the same channel.
- Reset (rst_n low, any time, mid-count included): sync flops to 0 (released), FSM IDLE, all counters 0, all outputs 0. A button held through reset is re-detected as a fresh press after rst_n rises.

## Timing

- All outputs registered; reset value 0 on every output bit.
- Press latency: raw input stable pressed from before edge 1 -> sync_1=1 after edge 2 -> press_pulse and button_state high after edge DEBOUNCE_CYCLES+2. Release latency identical.
- Minimum accepted pulse: sync_1 high for exactly DEBOUNCE_CYCLES consecutive cycles; DEBOUNCE_CYCLES-1 is rejected.
- Pulses are exactly one clk cycle wide; button_state changes on the same edge as press/release_pulse.
- First repeat_pulse REPEAT_DELAY cycles after press_pulse; then every REPEAT_PERIOD cycles.

## Test plan

- DEBOUNCE_CYCLES=4, CHANNELS=1: clean press at edge 0 held 20 cycles -> press_pulse single cycle after edge 6, button_state 1; release -> release_pulse 6 edges after, button_state 0.
- Bounce: input high 3 cycles, low 1, high 3, low -> no press_pulse, button_state stays 0; high 4 cycles -> exactly one press_pulse.
- Repeat: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, repeat_en=1, hold 30 cycles -> repeat_pulse 10, 13, 16, 19... cycles after press_pulse; repeat_en=0 -> none.
- ACTIVE_LOW=1, CHANNELS=4: drive channels 0 and 2 low with different start times -> independent press_pulses at own DEBOUNCE_CYCLES+2 latency; channels 1,3 silent.
- Reset mid-operation: rst_n low during PRESS_WAIT and during HELD -> all outputs 0 asynchronously; button still held after release -> new press_pulse at DEBOUNCE_CYCLES+2 edges.
- Release-bounce during repeat: in HELD, input low 2 cycles (DEBOUNCE_CYCLES=4) -> no release_pulse, repeat schedule shifted by exactly 2 cycles.
